// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// ps2_mouse_pkg: shared types and constants for the PS/2 mouse packet decoder.
//   state_t       - packet alignment FSM states
//   B0 bit index  - field positions inside the first (status) byte of a packet
//   POS_W_DEFAULT - default cursor coordinate width
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XS      = 4;
  localparam int YS      = 5;
  localparam int XO      = 6;
  localparam int YO      = 7;

  localparam int POS_W_DEFAULT = 10;

endpackage

// File: rtl/ps2_mouse_packet_decoder_axis_accum.sv
// axis_accum: one cursor axis. Sign-extends a 9-bit two's complement mouse
// delta, adds it to (or subtracts it from, when INVERT=1) the current
// position, clamps to 0..MAX and registers the result on load.
// Ports:
//   clk, reset   clock, synchronous active-high reset (pos <= INIT)
//   load         commit strobe for the new position
//   delta_sign   bit 8 of the delta
//   delta_low    bits 7:0 of the delta
//   delta_ovf    overflow flag; forces the delta to zero
//   pos          registered clamped position
module axis_accum #(
  parameter int MAX    = 639,
  parameter int INIT   = 320,
  parameter int POS_W  = 10,
  parameter int INVERT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             delta_sign,
  input  logic [7:0]       delta_low,
  input  logic             delta_ovf,
  output logic [POS_W-1:0] pos
);

  // Two extra bits: one for sign, one so position + max delta cannot wrap.
  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  logic signed [8:0]    delta9;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] cur;
  logic signed [SW-1:0] sum;
  logic [POS_W-1:0]     pos_nx;

  always_comb begin
    delta9 = $signed({delta_sign, delta_low});
    delta  = delta_ovf ? '0 : SW'(delta9);
    cur    = $signed({2'b00, pos});
    if (INVERT != 0) sum = cur - delta;
    else             sum = cur + delta;

    if (sum < 0)          pos_nx = '0;
    else if (sum > MAX_S) pos_nx = POS_W'(MAX);
    else                  pos_nx = sum[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)     pos <= POS_W'(INIT);
    else if (load) pos <= pos_nx;
  end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: aligns the received PS/2 byte stream into 3-byte
// mouse packets and keeps a clamped absolute cursor position and button state.
//
// state   | meaning
// WAIT_B0 | idle / expecting status byte (bit 3 must be 1)
// WAIT_B1 | status byte held, expecting X delta low byte
// WAIT_B2 | X byte held, expecting Y delta low byte; commit on arrival
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   rx_valid, rx_data[7:0]        received byte strobe and data
//   rx_err                        upstream parity/framing error strobe
//   cursor_x, cursor_y            absolute position (y = 0 is top of screen)
//   btn_left/right/middle         button state from last complete packet
//   pkt_valid                     pulse: cursor/buttons just updated
//   sync_err                      pulse: byte dropped or partial packet discarded
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int POS_W   = POS_W_DEFAULT,
  parameter int TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic             btn_left,
  output logic             btn_right,
  output logic             btn_middle,
  output logic             pkt_valid,
  output logic             sync_err
);

  localparam logic [23:0] TMO_LIM = 24'(TIMEOUT);

  state_t      state, state_nx;
  logic [2:0]  btn_hold;
  logic        xs_hold, ys_hold, xo_hold, yo_hold;
  logic [7:0]  x_low_hold;
  logic [23:0] tmo_cnt;
  logic        tmo_hit;
  logic        take_b0, take_b1, commit;
  logic        pkt_nx, err_nx;

  always_comb begin
    state_nx = state;
    take_b0  = 1'b0;
    take_b1  = 1'b0;
    commit   = 1'b0;
    pkt_nx   = 1'b0;
    err_nx   = 1'b0;
    tmo_hit  = (tmo_cnt >= TMO_LIM);

    if (rx_err) begin
      // Error beats a coincident byte; the byte is discarded with the packet.
      state_nx = WAIT_B0;
      err_nx   = 1'b1;
    end else begin
      case (state)
        WAIT_B0: begin
          if (rx_valid) begin
            if (rx_data[ALWAYS1]) begin
              take_b0  = 1'b1;
              state_nx = WAIT_B1;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        WAIT_B1: begin
          if (rx_valid) begin
            take_b1  = 1'b1;
            state_nx = WAIT_B2;
          end else if (tmo_hit) begin
            state_nx = WAIT_B0;
            err_nx   = 1'b1;
          end
        end
        WAIT_B2: begin
          if (rx_valid) begin
            commit   = 1'b1;
            pkt_nx   = 1'b1;
            state_nx = WAIT_B0;
          end else if (tmo_hit) begin
            state_nx = WAIT_B0;
            err_nx   = 1'b1;
          end
        end
        default: state_nx = WAIT_B0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_B0;
      btn_hold   <= '0;
      xs_hold    <= 1'b0;
      ys_hold    <= 1'b0;
      xo_hold    <= 1'b0;
      yo_hold    <= 1'b0;
      x_low_hold <= '0;
      tmo_cnt    <= '0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      pkt_valid  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      pkt_valid <= pkt_nx;
      sync_err  <= err_nx;

      if (take_b0) begin
        btn_hold <= {rx_data[BTN_M], rx_data[BTN_R], rx_data[BTN_L]};
        xs_hold  <= rx_data[XS];
        ys_hold  <= rx_data[YS];
        xo_hold  <= rx_data[XO];
        yo_hold  <= rx_data[YO];
      end
      if (take_b1) x_low_hold <= rx_data;

      if (commit) begin
        btn_left   <= btn_hold[0];
        btn_right  <= btn_hold[1];
        btn_middle <= btn_hold[2];
      end

      // Held at zero whenever idle; restarts on every accepted byte; saturates.
      if (state_nx == WAIT_B0 || take_b0 || take_b1 || commit) tmo_cnt <= '0;
      else if (!tmo_hit)                                       tmo_cnt <= tmo_cnt + 24'd1;
    end
  end

  axis_accum #(
    .MAX(X_MAX), .INIT(X_INIT), .POS_W(POS_W), .INVERT(0)
  ) u_axis_x (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .delta_sign (xs_hold),
    .delta_low  (x_low_hold),
    .delta_ovf  (xo_hold),
    .pos        (cursor_x)
  );

  // Y byte is consumed straight off rx_data in the commit cycle.
  axis_accum #(
    .MAX(Y_MAX), .INIT(Y_INIT), .POS_W(POS_W), .INVERT(1)
  ) u_axis_y (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .delta_sign (ys_hold),
    .delta_low  (rx_data),
    .delta_ovf  (yo_hold),
    .pos        (cursor_y)
  );

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
module tb_ps2_mouse_packet_decoder;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_err = 1'b0;
  logic [9:0] cursor_x, cursor_y;
  logic       btn_left, btn_right, btn_middle, pkt_valid, sync_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       is_err;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ps2_mouse_packet_decoder #(
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
    .POS_W(10), .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .pkt_valid  (pkt_valid),
    .sync_err   (sync_err)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_pkt(input int x, input int y, input logic [2:0] btn);
    exp_t e;
    e.is_err = 1'b0; e.x = 10'(x); e.y = 10'(y); e.btn = btn;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.x = '0; e.y = '0; e.btn = '0;
    exp_q.push_back(e);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0); send(b1); send(b2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check({tag, " rst cursor_x"}, int'(cursor_x), 320);
    check({tag, " rst cursor_y"}, int'(cursor_y), 240);
    check({tag, " rst buttons"}, int'({btn_middle, btn_right, btn_left}), 0);
    check({tag, " rst pulses"}, int'({pkt_valid, sync_err}), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && (pkt_valid || sync_err)) begin
      if (pkt_valid && sync_err) begin
        checks++; errors++;
        $display("FAIL pulse_overlap: got pkt_valid=1 sync_err=1 expected exclusive");
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got pkt_valid=%0d sync_err=%0d expected none", pkt_valid, sync_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          check("sync_err pulse", int'({pkt_valid, sync_err}), 1);
        end else begin
          check("pkt_valid pulse", int'({pkt_valid, sync_err}), 2);
          check("pkt cursor_x", int'(cursor_x), int'(e.x));
          check("pkt cursor_y", int'(cursor_y), int'(e.y));
          check("pkt buttons", int'({btn_middle, btn_right, btn_left}), int'(e.btn));
        end
      end
    end
  end

  initial begin
    @(negedge clk);

    // Basic packet: +5 X, +3 Y (screen up), left button.
    do_reset("t1");
    push_pkt(325, 237, 3'b001);
    send3(8'h09, 8'h05, 8'h03);
    idle(3);
    check("t1 hold cursor_x", int'(cursor_x), 325);

    // Large negative deltas clamp: X to 0, Y to Y_MAX.
    do_reset("t2");
    push_pkt(64, 479, 3'b000);
    send3(8'h38, 8'h00, 8'h00);
    push_pkt(0, 479, 3'b000);
    send3(8'h38, 8'h00, 8'h00);
    idle(3);

    // Misaligned byte dropped, then realigned packet.
    do_reset("t3");
    push_err();
    send(8'h05);
    push_pkt(321, 239, 3'b000);
    send3(8'h08, 8'h01, 8'h01);
    idle(3);

    // Inter-byte timeout discards partial packet.
    do_reset("t4");
    send(8'h08); send(8'h10);
    push_err();
    idle(TMO + 5);
    push_pkt(322, 240, 3'b000);
    send3(8'h08, 8'h02, 8'h00);
    idle(3);

    // Byte arriving exactly on the timeout cycle is accepted.
    do_reset("t5");
    push_pkt(321, 238, 3'b000);
    send(8'h08); idle(TMO);
    send(8'h01); idle(TMO);
    send(8'h02);
    idle(3);

    // X overflow: X delta ignored, Y and right button applied.
    do_reset("t6");
    push_pkt(320, 236, 3'b010);
    send3(8'h4A, 8'hFF, 8'h04);
    idle(3);

    // rx_err with a coincident byte in WAIT_B2: packet dropped.
    do_reset("t7");
    send(8'h08); send(8'h01);
    push_err();
    rx_err = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    @(negedge clk);
    rx_err = 1'b0; rx_valid = 1'b0;
    idle(2);
    check("t7 cursor_x kept", int'(cursor_x), 320);
    push_pkt(323, 240, 3'b100);
    send3(8'h0C, 8'h03, 8'h00);
    idle(3);

    // Reset during WAIT_B1 after a moved cursor: partial discarded, no pulses.
    push_pkt(330, 240, 3'b000);
    send3(8'h08, 8'h07, 8'h00);
    send(8'h09);
    do_reset("t8");
    idle(2);
    push_pkt(324, 240, 3'b000);
    send3(8'h08, 8'h04, 8'h00);
    idle(5);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Downstream stage of the PS/2 mouse receiver: consumes the stream of received data bytes, aligns and assembles standard 3-byte mouse movement packets, and maintains a clamped absolute cursor position plus button state for the Space Invaders player/cannon control logic. Protocol and framing are handled upstream; this block owns packet alignment, resynchronisation, sign extension and position accumulation.

## Interface
Parameters:
- X_MAX, 639, maximum cursor_x value (inclusive)
- Y_MAX, 479, maximum cursor_y value (inclusive)
- X_INIT, 320, cursor_x after reset
- Y_INIT, 240, cursor_y after reset
- POS_W, 10, width of cursor outputs
- TIMEOUT, 2000000, clk cycles allowed between bytes of one packet (20 ms at 100 MHz); counter is 24 bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte, LSB = first data bit on the wire
- rx_err  in  1  one-cycle strobe, upstream parity/framing error
- cursor_x  out  POS_W  absolute X, 0..X_MAX
- cursor_y  out  POS_W  absolute Y, 0..Y_MAX, 0 = top of screen
- btn_left, btn_right, btn_middle  out  1 each  button state from last complete packet
- pkt_valid  out  1  one-cycle pulse, cursor/buttons just updated
- sync_err  out  1  one-cycle pulse, packet discarded or byte dropped

## Operation
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2.
- WAIT_B0: on rx_valid, accept byte only if rx_data[3]=1 (always-one bit) -> store as B0, go WAIT_B1; otherwise drop byte, pulse sync_err, stay.
- WAIT_B1: on rx_valid store B1 (X delta low), go WAIT_B2.
- WAIT_B2: on rx_valid store B2 (Y delta low), commit packet, go WAIT_B0.
- B0 fields: [0] left, [1] right, [2] middle, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Delta = 9-bit two's complement {sign, low byte}, sign-extended to POS_W+2 bits.
- X: new_x = cursor_x + dx. Y: new_y = cursor_y - dy (mouse up = screen up).
- Clamp: result <0 -> 0; result > MAX -> MAX.
- Overflow bit set on an axis: that axis's delta forced to 0; buttons and other axis still updated.
- rx_err in any state: drop any partial packet, go WAIT_B0, pulse sync_err.
- Inter-byte timeout: counter clears on every accepted byte; in WAIT_B1/WAIT_B2 reaching TIMEOUT -> WAIT_B0, pulse sync_err. Counter held at 0 in WAIT_B0.

## Timing
- Reset values: state WAIT_B0, cursor_x=X_INIT, cursor_y=Y_INIT, buttons 0, pkt_valid 0, sync_err 0, timeout counter 0.
- Reset mid-packet: partial packet discarded, no pulses emitted.
- Latency: pkt_valid, cursor_x/y and buttons all update in the cycle after the clk edge sampling rx_valid for B2 (1-cycle registered).
- Outputs hold value between packets; no intermediate values visible.
- rx_valid and rx_err in the same cycle: error wins, byte discarded.
- Timeout and rx_valid in the same cycle: byte accepted, no timeout.
- sync_err asserted in the cycle after the offending event; never simultaneous with pkt_valid.
- Back-to-back bytes on consecutive cycles must be accepted (no dead cycles).

## Structure
- Package ps2_mouse_pkg: state enum, B0 bit-position constants (BTN_L=0, BTN_R=1, BTN_M=2, ALWAYS1=3, XS=4, YS=5, XO=6, YO=7), default POS_W.
- One sub-module natural: axis_accum (params MAX, INIT, POS_W, INVERT) — sign-extends 9-bit delta, adds or subtracts, clamps, registers result on load strobe; instantiated for X (INVERT=0) and Y (INVERT=1).

## Test plan
- Reset, then packet 0x09,0x05,0x03 -> pkt_valid one cycle later, cursor_x=325, cursor_y=237, btn_left=1.
- From reset, packet 0x38,0x00,0x00 (X=-256, Y=-256) twice -> cursor_x=0 after 2nd, cursor_y=479 after 2nd (clamped).
- Misaligned byte 0x05 then valid packet 0x08,0x01,0x01 -> sync_err pulse for 0x05, then cursor_x=321, cursor_y=239.
- Bytes 0x08,0x10 then TIMEOUT cycles idle -> sync_err, state WAIT_B0; next packet 0x08,0x02,0x00 -> cursor_x=322.
- Packet 0x4A,0xFF,0x04 (X overflow, right button) -> cursor_x unchanged 320, cursor_y=236, btn_right=1.
- rx_err during WAIT_B2, and reset asserted during WAIT_B1 -> partial packet discarded, no pkt_valid, outputs as specified.
